rattlesnake_protect_event_handler: RTL and testbench



---
 rtl/rattlesnake_protect_event_handler.sv | 201 ++++++++++++++++++++
 tb/tb_rattlesnake_protect_event_handler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rattlesnake_protect_event_handler.sv
`default_nettype none
// ============================================================================
// Module   : rattlesnake_protect_event_handler
// Brief    : Edge-detects the indirect-pointer protection alert, logs the
//            offending store {PC, address} into a small circular FIFO, keeps
//            a saturating event count and a sticky overflow flag, and raises
//            a level interrupt handshaken against the exception handler.
// Revision : 1.0 - initial release
// ============================================================================
module rattlesnake_protect_event_handler #(
  parameter int PC_BITWIDTH = 32,
  parameter int XLEN        = 32,
  parameter int LOG_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   enable,
  input  logic                   indirect_protect_active,
  input  logic [PC_BITWIDTH-1:0] store_pc_in,
  input  logic [XLEN-1:0]        store_addr_in,
  input  logic                   exception_handler_active,
  input  logic                   rd_pop,
  input  logic                   clear_overflow,
  output logic                   rd_valid,
  output logic [PC_BITWIDTH-1:0] rd_pc,
  output logic [XLEN-1:0]        rd_addr,
  output logic                   irq_req,
  output logic                   overflow,
  output logic [15:0]            event_count
);

  localparam int PTR_W   = $clog2(LOG_DEPTH);
  localparam int CNT_W   = $clog2(LOG_DEPTH + 1);
  localparam int ENTRY_W = PC_BITWIDTH + XLEN;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LOG_DEPTH);
  localparam logic [15:0]      EVT_MAX   = 16'hFFFF;

  // One-hot interrupt FSM encoding
  localparam logic [2:0] S_IDLE    = 3'b001;
  localparam logic [2:0] S_REQ     = 3'b010;
  localparam logic [2:0] S_SERVICE = 3'b100;

  logic                   alert_d;
  logic                   evt_q;
  logic [PC_BITWIDTH-1:0] evt_pc_q;
  logic [XLEN-1:0]        evt_addr_q;

  logic [ENTRY_W-1:0]     log_mem [LOG_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;

  logic                   fifo_full;
  logic                   do_pop;
  logic                   do_push;
  logic                   do_drop;
  logic [ENTRY_W-1:0]     head_entry;

  logic [2:0]             state;
  logic [2:0]             state_nxt;

  // FIFO control: a pop frees the slot the same cycle, so a push into a full
  // FIFO succeeds when it coincides with a pop; otherwise the event is dropped.
  assign fifo_full  = (count == CNT_FULL);
  assign do_pop     = rd_pop & (count != '0);
  assign do_push    = evt_q & (~fifo_full | do_pop);
  assign do_drop    = evt_q & fifo_full & ~do_pop;
  assign head_entry = log_mem[rd_ptr];

  // Head view is combinational from rd_ptr and forced to zero while empty
  assign rd_valid = (count != '0);
  assign rd_pc    = rd_valid ? head_entry[ENTRY_W-1:XLEN] : '0;
  assign rd_addr  = rd_valid ? head_entry[XLEN-1:0]       : '0;

  // Alert edge detect; the offending store is captured with the event so the
  // push on the following edge does not depend on the alert still being held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alert_d    <= 1'b0;
      evt_q      <= 1'b0;
      evt_pc_q   <= '0;
      evt_addr_q <= '0;
    end else if (sync_reset) begin
      alert_d    <= 1'b0;
      evt_q      <= 1'b0;
      evt_pc_q   <= '0;
      evt_addr_q <= '0;
    end else begin
      alert_d    <= indirect_protect_active;
      evt_q      <= indirect_protect_active & ~alert_d;
      evt_pc_q   <= store_pc_in;
      evt_addr_q <= store_addr_in;
    end
  end

  // Log storage; never cleared, contents are hidden while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push && !sync_reset) begin
      log_mem[wr_ptr] <= {evt_pc_q, evt_addr_q};
    end
  end

  // Pointers and occupancy; pointer width matches LOG_DEPTH so wrap is free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (sync_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Saturating event counter (dropped events included) and sticky overflow,
  // where a new drop takes priority over a coincident clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_count <= '0;
      overflow    <= 1'b0;
    end else if (sync_reset) begin
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (evt_q && (event_count != EVT_MAX)) begin
        event_count <= event_count + 16'd1;
      end
      if (do_drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Interrupt FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (sync_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Interrupt FSM next-state; unknown encodings recover to idle
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (enable && rd_valid && !exception_handler_active) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (exception_handler_active) begin
          state_nxt = S_SERVICE;
        end else if (!enable) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_SERVICE: begin
        if (!exception_handler_active) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SERVICE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Interrupt FSM outputs, decoded purely from the state register
  always_comb begin
    irq_req = (state == S_REQ);
  end

endmodule
`default_nettype wire

// File: tb/tb_rattlesnake_protect_event_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rattlesnake_protect_event_handler
// Brief    : Directed self-checking bench for rattlesnake_protect_event_handler
// Revision : 1.0 - initial release
// ============================================================================
module tb_rattlesnake_protect_event_handler;

  logic        clk;
  logic        reset_n;
  logic        sync_reset;
  logic        enable;
  logic        indirect_protect_active;
  logic [31:0] store_pc_in;
  logic [31:0] store_addr_in;
  logic        exception_handler_active;
  logic        rd_pop;
  logic        clear_overflow;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_addr;
  logic        irq_req;
  logic        overflow;
  logic [15:0] event_count;

  int tests_run;
  int tests_failed;

  rattlesnake_protect_event_handler #(
    .PC_BITWIDTH(32),
    .XLEN       (32),
    .LOG_DEPTH  (4)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .sync_reset              (sync_reset),
    .enable                  (enable),
    .indirect_protect_active (indirect_protect_active),
    .store_pc_in             (store_pc_in),
    .store_addr_in           (store_addr_in),
    .exception_handler_active(exception_handler_active),
    .rd_pop                  (rd_pop),
    .clear_overflow          (clear_overflow),
    .rd_valid                (rd_valid),
    .rd_pc                   (rd_pc),
    .rd_addr                 (rd_addr),
    .irq_req                 (irq_req),
    .overflow                (overflow),
    .event_count             (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One alert pulse; on return the entry has been pushed
  task automatic fire(input logic [31:0] pc, input logic [31:0] addr);
    indirect_protect_active = 1'b1;
    store_pc_in             = pc;
    store_addr_in           = addr;
    step();
    indirect_protect_active = 1'b0;
    step();
  endtask

  // Check head entry then pop it
  task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_pc"},    64'(rd_pc),    64'(pc));
    chk({tag, "_addr"},  64'(rd_addr),  64'(addr));
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
  endtask

  initial begin
    tests_run                = 0;
    tests_failed             = 0;
    reset_n                  = 1'b0;
    sync_reset               = 1'b0;
    enable                   = 1'b0;
    indirect_protect_active  = 1'b0;
    store_pc_in              = '0;
    store_addr_in            = '0;
    exception_handler_active = 1'b0;
    rd_pop                   = 1'b0;
    clear_overflow           = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_pc",    64'(rd_pc),    64'd0);
    chk("rst_addr",  64'(rd_addr),  64'd0);
    chk("rst_irq",   64'(irq_req),  64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_cnt",   64'(event_count), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // ---------------- single event ----------------
    enable                  = 1'b1;
    indirect_protect_active = 1'b1;
    store_pc_in             = 32'h8004_3298;
    store_addr_in           = 32'h2000_0100;
    step();                                   // edge t
    chk("se_valid_t",   64'(rd_valid), 64'd0);
    step();                                   // edge t+1
    chk("se_valid_t1",  64'(rd_valid), 64'd1);
    chk("se_pc",        64'(rd_pc),    64'h8004_3298);
    chk("se_addr",      64'(rd_addr),  64'h2000_0100);
    chk("se_cnt",       64'(event_count), 64'd1);
    chk("se_irq_t1",    64'(irq_req),  64'd0);
    step();                                   // edge t+2
    chk("se_irq_t2",    64'(irq_req),  64'd1);
    step();
    step();                                   // alert held 5 edges
    indirect_protect_active = 1'b0;
    step();
    chk("se_held_cnt",  64'(event_count), 64'd1);

    // ---------------- handler handshake ----------------
    exception_handler_active = 1'b1;
    step();
    chk("hs_irq_low",   64'(irq_req),  64'd0);
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    chk("hs_empty",     64'(rd_valid), 64'd0);
    chk("hs_pc_zero",   64'(rd_pc),    64'd0);
    chk("hs_addr_zero", 64'(rd_addr),  64'd0);
    step();
    chk("hs_irq_svc",   64'(irq_req),  64'd0);
    exception_handler_active = 1'b0;
    step();
    step();
    chk("hs_irq_idle",  64'(irq_req),  64'd0);
    enable = 1'b0;

    // ---------------- overflow ----------------
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    chk("sr_cnt",       64'(event_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      fire(32'h1000_0000 + 32'(i), 32'h3000_0000 + 32'(i * 4));
    end
    chk("ov_flag",      64'(overflow),    64'd1);
    chk("ov_cnt",       64'(event_count), 64'd6);
    chk("ov_head_pc",   64'(rd_pc),       64'h1000_0000);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ov_clear",     64'(overflow),    64'd0);

    // ---------------- full with simultaneous pop ----------------
    indirect_protect_active = 1'b1;
    store_pc_in             = 32'hCAFE_0001;
    store_addr_in           = 32'hBEEF_0004;
    step();
    indirect_protect_active = 1'b0;
    rd_pop                  = 1'b1;
    step();
    rd_pop                  = 1'b0;
    chk("fp_ovf",       64'(overflow),    64'd0);
    chk("fp_cnt",       64'(event_count), 64'd7);
    pop_check("fp_e1", 32'h1000_0001, 32'h3000_0004);
    pop_check("fp_e2", 32'h1000_0002, 32'h3000_0008);
    pop_check("fp_e3", 32'h1000_0003, 32'h3000_000C);
    pop_check("fp_new", 32'hCAFE_0001, 32'hBEEF_0004);
    chk("fp_drained",   64'(rd_valid),    64'd0);

    // ---------------- empty: pop ignored, pop+event just pushes ----------------
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    chk("em_pop_ign",   64'(rd_valid),    64'd0);
    indirect_protect_active = 1'b1;
    store_pc_in             = 32'h0000_ABCD;
    store_addr_in           = 32'h0000_1230;
    step();
    indirect_protect_active = 1'b0;
    rd_pop                  = 1'b1;
    step();
    rd_pop                  = 1'b0;
    pop_check("em_push", 32'h0000_ABCD, 32'h0000_1230);
    chk("em_after",     64'(rd_valid),    64'd0);

    // ---------------- pointer wrap ----------------
    for (int i = 0; i < 10; i++) begin
      fire(32'hA000_0000 + 32'(i * 16), 32'h5000_0000 + 32'(i * 8));
      pop_check("wrap", 32'hA000_0000 + 32'(i * 16), 32'h5000_0000 + 32'(i * 8));
    end
    chk("wrap_empty",   64'(rd_valid),    64'd0);

    // ---------------- sync reset mid-request ----------------
    enable = 1'b1;
    fire(32'h1111_1111, 32'h2222_2222);
    fire(32'h3333_3333, 32'h4444_4444);
    chk("sy_irq_pre",   64'(irq_req),     64'd1);
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    chk("sy_irq",       64'(irq_req),     64'd0);
    chk("sy_valid",     64'(rd_valid),    64'd0);
    chk("sy_pc",        64'(rd_pc),       64'd0);
    chk("sy_addr",      64'(rd_addr),     64'd0);
    chk("sy_cnt",       64'(event_count), 64'd0);
    fire(32'h5555_0000, 32'h6666_0000);
    chk("sy_relog_pc",  64'(rd_pc),       64'h5555_0000);
    chk("sy_relog_cnt", 64'(event_count), 64'd1);
    step();
    chk("sy_irq_again", 64'(irq_req),     64'd1);

    // ---------------- asynchronous reset ----------------
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_irq",       64'(irq_req),     64'd0);
    chk("ar_valid",     64'(rd_valid),    64'd0);
    chk("ar_pc",        64'(rd_pc),       64'd0);
    chk("ar_cnt",       64'(event_count), 64'd0);
    indirect_protect_active = 1'b1;
    store_pc_in             = 32'h7777_0010;
    store_addr_in           = 32'h8888_0020;
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("ar_held_valid", 64'(rd_valid),    64'd1);
    chk("ar_held_pc",    64'(rd_pc),       64'h7777_0010);
    chk("ar_held_cnt",   64'(event_count), 64'd1);
    step();
    step();
    chk("ar_held_once",  64'(event_count), 64'd1);
    indirect_protect_active = 1'b0;
    enable = 1'b0;
    step();

    // ---------------- event_count saturation ----------------
    force dut.event_count = 16'hFFFD;
    #1;
    release dut.event_count;
    fire(32'h0, 32'h0);
    chk("sat_fffe",     64'(event_count), 64'hFFFE);
    fire(32'h0, 32'h0);
    chk("sat_ffff",     64'(event_count), 64'hFFFF);
    fire(32'h0, 32'h0);
    chk("sat_hold",     64'(event_count), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
